// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the arbitrating stream mux.
// Holds the arbitration-mode enum and the wrapped priority scan.
package stream_arb_pkg;

  typedef enum logic [1:0] {
    ARB_SEL,
    ARB_RR,
    ARB_PRIO
  } arb_mode_e;

  localparam int MAX_INP = 64;
  localparam int MAX_W   = 6;

  // First set bit of vld[0..n-1] scanning upward from start, wrapping.
  // Returns -1 when no bit is set.
  function automatic int wrap_scan(
    input logic [MAX_INP-1:0] vld,
    input int                 n,
    input int                 start
  );
    int res;
    int idx;
    res = -1;
    // Descending so the closest hit to start is written last.
    for (int k = MAX_INP - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = start + k;
        if (idx >= n) idx = idx - n;
        if (vld[idx[MAX_W-1:0]]) res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_arb_gnt.sv
// Combinational grant picker: select, round-robin or fixed priority.
// Ports: valid/sel/rr/lock/lock_idx in; gnt index and gnt_valid out.
module stream_arb_gnt
  import stream_arb_pkg::*;
#(
  parameter int        N_INP    = 2,
  parameter arb_mode_e ARB_MODE = ARB_RR,
  parameter int        SEL_W    = (N_INP > 1) ? $clog2(N_INP) : 1
) (
  input  logic [N_INP-1:0] valid,
  input  logic [SEL_W-1:0] sel,
  input  logic [SEL_W-1:0] rr,
  input  logic             lock,
  input  logic [SEL_W-1:0] lock_idx,
  output logic [SEL_W-1:0] gnt,
  output logic             gnt_valid
);

  logic [MAX_INP-1:0] vpad;
  int                 scan;

  always_comb begin
    vpad = '0;
    vpad[N_INP-1:0] = valid;
    gnt = '0;
    gnt_valid = 1'b0;
    scan = -1;
    if (N_INP == 1) begin
      gnt_valid = valid[0];
    end else if (ARB_MODE == ARB_SEL) begin
      // Out-of-range select matches no input and grants nothing.
      gnt = sel;
      for (int i = 0; i < N_INP; i++) begin
        if (sel == SEL_W'(i)) gnt_valid = valid[i];
      end
    end else if (lock) begin
      gnt = lock_idx;
      for (int i = 0; i < N_INP; i++) begin
        if (lock_idx == SEL_W'(i)) gnt_valid = valid[i];
      end
    end else begin
      scan = wrap_scan(vpad, N_INP,
                       (ARB_MODE == ARB_RR) ? int'(rr) : 0);
      if (scan >= 0) begin
        gnt = SEL_W'(scan);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_arb_mux.sv
// N-input valid/ready stream mux with internal arbitration and grant lock.
// Ports: clk_i/rst_i, inp_* (N streams), oup_* (one stream + source idx).
module stream_arb_mux
  import stream_arb_pkg::*;
#(
  parameter type       DATA_T   = logic,
  parameter int        N_INP    = 2,
  parameter arb_mode_e ARB_MODE = ARB_RR,
  parameter bit        OUT_REG  = 1'b0,
  parameter int        SEL_W    = (N_INP > 1) ? $clog2(N_INP) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  DATA_T [N_INP-1:0]       inp_data_i,
  input  logic  [N_INP-1:0]       inp_valid_i,
  output logic  [N_INP-1:0]       inp_ready_o,
  input  logic  [SEL_W-1:0]       inp_sel_i,
  output DATA_T                   oup_data_o,
  output logic                    oup_valid_o,
  input  logic                    oup_ready_i,
  output logic  [SEL_W-1:0]       oup_idx_o
);

  if (N_INP < 1 || N_INP > MAX_INP) begin : g_bad_n
    $fatal(1, "stream_arb_mux: N_INP out of range");
  end

  logic [SEL_W-1:0] rr_q;
  logic [SEL_W-1:0] lock_idx_q;
  logic             lock_q;
  logic [SEL_W-1:0] gnt;
  logic             gnt_valid;
  logic             in_rdy;
  logic             in_fire;
  DATA_T            gnt_data;

  stream_arb_gnt #(
    .N_INP    (N_INP),
    .ARB_MODE (ARB_MODE),
    .SEL_W    (SEL_W)
  ) u_gnt (
    .valid     (inp_valid_i),
    .sel       (inp_sel_i),
    .rr        (rr_q),
    .lock      (lock_q),
    .lock_idx  (lock_idx_q),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_INP; i++) begin
      if (gnt == SEL_W'(i)) gnt_data = inp_data_i[i];
    end
  end

  assign in_fire = gnt_valid && in_rdy;

  always_comb begin
    inp_ready_o = '0;
    for (int i = 0; i < N_INP; i++) begin
      if (gnt_valid && gnt == SEL_W'(i)) inp_ready_o[i] = in_rdy;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      if (in_fire) begin
        rr_q <= (gnt == SEL_W'(N_INP - 1)) ? '0 : gnt + 1'b1;
      end
      // Pin the grant on an offered-but-stalled beat.
      if (ARB_MODE != ARB_SEL) begin
        if (in_fire) begin
          lock_q <= 1'b0;
        end else if (gnt_valid) begin
          lock_q     <= 1'b1;
          lock_idx_q <= gnt;
        end
      end
    end
  end

  if (OUT_REG) begin : g_reg
    logic             full_q;
    DATA_T            data_q;
    logic [SEL_W-1:0] idx_q;

    // Accept while empty or draining: keeps one beat per cycle.
    assign in_rdy = !full_q || oup_ready_i;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        full_q <= 1'b0;
        data_q <= '0;
        idx_q  <= '0;
      end else if (in_fire) begin
        full_q <= 1'b1;
        data_q <= gnt_data;
        idx_q  <= gnt;
      end else if (oup_ready_i) begin
        full_q <= 1'b0;
      end
    end

    assign oup_valid_o = full_q;
    assign oup_data_o  = data_q;
    assign oup_idx_o   = idx_q;
  end else begin : g_comb
    assign in_rdy      = oup_ready_i;
    assign oup_valid_o = gnt_valid;
    assign oup_data_o  = gnt_data;
    assign oup_idx_o   = gnt;
  end

`ifndef SYNTHESIS
  a_ready_onehot0 : assert property (
    @(posedge clk_i) disable iff (rst_i)
    $onehot0(inp_ready_o));

  a_out_stable : assert property (
    @(posedge clk_i) disable iff (rst_i)
    oup_valid_o && !oup_ready_i |=>
      oup_valid_o && $stable(oup_data_o) && $stable(oup_idx_o));

  if (ARB_MODE != ARB_SEL) begin : g_hold_chk
    for (genvar i = 0; i < N_INP; i++) begin : g_in
      a_valid_hold : assert property (
        @(posedge clk_i) disable iff (rst_i)
        inp_valid_i[i] && !inp_ready_o[i] |=> inp_valid_i[i]);
    end
  end

  if (ARB_MODE == ARB_SEL && N_INP > 1) begin : g_sel_chk
    a_sel_range : assert property (
      @(posedge clk_i) disable iff (rst_i)
      {1'b0, inp_sel_i} < (SEL_W + 1)'(N_INP));
  end
`endif

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench for stream_arb_mux across RR, PRIO, SEL and N=1 builds.
// Each instance has its own stimulus; clock and reset are shared.
module tb_stream_arb_mux;
  import stream_arb_pkg::*;

  typedef logic [7:0] byte_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // RR, N=4, comb
  logic [3:0][7:0] rr_d;
  logic [3:0] rr_v, rr_r;
  logic [1:0] rr_sel, rr_oi;
  logic [7:0] rr_od;
  logic rr_ov, rr_or;
  // PRIO, N=4, comb
  logic [3:0][7:0] pr_d;
  logic [3:0] pr_v, pr_r;
  logic [1:0] pr_sel, pr_oi;
  logic [7:0] pr_od;
  logic pr_ov, pr_or;
  // SEL, N=2, registered
  logic [1:0][7:0] sl_d;
  logic [1:0] sl_v, sl_r;
  logic sl_sel, sl_oi;
  logic [7:0] sl_od;
  logic sl_ov, sl_or;
  // RR, N=4, registered
  logic [3:0][7:0] rq_d;
  logic [3:0] rq_v, rq_r;
  logic [1:0] rq_sel, rq_oi;
  logic [7:0] rq_od;
  logic rq_ov, rq_or;
  // N=1 comb / registered
  logic [0:0][7:0] o0_d, o1_d;
  logic [0:0] o0_v, o0_r, o1_v, o1_r;
  logic o0_sel, o0_oi, o1_sel, o1_oi;
  logic [7:0] o0_od, o1_od;
  logic o0_ov, o0_or, o1_ov, o1_or;

  stream_arb_mux #(.DATA_T(byte_t), .N_INP(4), .ARB_MODE(ARB_RR),
                   .OUT_REG(1'b0)) u_rr (
    .clk_i(clk), .rst_i(rst), .inp_data_i(rr_d), .inp_valid_i(rr_v),
    .inp_ready_o(rr_r), .inp_sel_i(rr_sel), .oup_data_o(rr_od),
    .oup_valid_o(rr_ov), .oup_ready_i(rr_or), .oup_idx_o(rr_oi));

  stream_arb_mux #(.DATA_T(byte_t), .N_INP(4), .ARB_MODE(ARB_PRIO),
                   .OUT_REG(1'b0)) u_pr (
    .clk_i(clk), .rst_i(rst), .inp_data_i(pr_d), .inp_valid_i(pr_v),
    .inp_ready_o(pr_r), .inp_sel_i(pr_sel), .oup_data_o(pr_od),
    .oup_valid_o(pr_ov), .oup_ready_i(pr_or), .oup_idx_o(pr_oi));

  stream_arb_mux #(.DATA_T(byte_t), .N_INP(2), .ARB_MODE(ARB_SEL),
                   .OUT_REG(1'b1)) u_sl (
    .clk_i(clk), .rst_i(rst), .inp_data_i(sl_d), .inp_valid_i(sl_v),
    .inp_ready_o(sl_r), .inp_sel_i(sl_sel), .oup_data_o(sl_od),
    .oup_valid_o(sl_ov), .oup_ready_i(sl_or), .oup_idx_o(sl_oi));

  stream_arb_mux #(.DATA_T(byte_t), .N_INP(4), .ARB_MODE(ARB_RR),
                   .OUT_REG(1'b1)) u_rq (
    .clk_i(clk), .rst_i(rst), .inp_data_i(rq_d), .inp_valid_i(rq_v),
    .inp_ready_o(rq_r), .inp_sel_i(rq_sel), .oup_data_o(rq_od),
    .oup_valid_o(rq_ov), .oup_ready_i(rq_or), .oup_idx_o(rq_oi));

  stream_arb_mux #(.DATA_T(byte_t), .N_INP(1), .ARB_MODE(ARB_RR),
                   .OUT_REG(1'b0)) u_o0 (
    .clk_i(clk), .rst_i(rst), .inp_data_i(o0_d), .inp_valid_i(o0_v),
    .inp_ready_o(o0_r), .inp_sel_i(o0_sel), .oup_data_o(o0_od),
    .oup_valid_o(o0_ov), .oup_ready_i(o0_or), .oup_idx_o(o0_oi));

  stream_arb_mux #(.DATA_T(byte_t), .N_INP(1), .ARB_MODE(ARB_RR),
                   .OUT_REG(1'b1)) u_o1 (
    .clk_i(clk), .rst_i(rst), .inp_data_i(o1_d), .inp_valid_i(o1_v),
    .inp_ready_o(o1_r), .inp_sel_i(o1_sel), .oup_data_o(o1_od),
    .oup_valid_o(o1_ov), .oup_ready_i(o1_or), .oup_idx_o(o1_oi));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_valids();
    rr_v = '0; pr_v = '0; sl_v = '0; rq_v = '0; o0_v = '0; o1_v = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_valids();
    tick();
    rst = 1'b0;
  endtask

  int e, s, rcv;
  logic inf;

  initial begin
    clear_valids();
    rr_sel = '0; pr_sel = '0; sl_sel = 1'b1; rq_sel = '0;
    o0_sel = 1'b1; o1_sel = 1'b1;
    rr_or = 1'b0; pr_or = 1'b0; sl_or = 1'b0; rq_or = 1'b0;
    o0_or = 1'b0; o1_or = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rr_d[i] = 8'(8'h10 + i);
      pr_d[i] = 8'(8'h20 + i);
      rq_d[i] = 8'(8'h30 + i);
    end
    sl_d = '0; o0_d = '0; o1_d = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state of the registered builds
    chk("rst_rq_valid", rq_ov, 0);
    chk("rst_rq_data", rq_od, 0);
    chk("rst_rq_idx", rq_oi, 0);
    chk("rst_sl_valid", sl_ov, 0);
    chk("rst_o1_valid", o1_ov, 0);
    chk("rst_rr_valid", rr_ov, 0);

    // RR, all valid, always ready: 0,1,2,3,0
    rr_v = 4'hF;
    rr_or = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      e = k % 4;
      chk("rr_all_idx", rr_oi, e);
      chk("rr_all_data", rr_od, 8'h10 + e);
      chk("rr_all_rdy", rr_r, 32'd1 << e);
      chk("rr_all_vld", rr_ov, 1);
      tick();
    end

    // RR, only inputs 1 and 3: 1,3,1,3
    do_reset();
    rr_v = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      e = (k % 2 == 0) ? 1 : 3;
      chk("rr_13_idx", rr_oi, e);
      chk("rr_13_data", rr_od, 8'h10 + e);
      chk("rr_13_rdy", rr_r, 32'd1 << e);
      tick();
    end
    do_reset();

    // PRIO: input 2 stalled 3 cycles, input 0 arrives in cycle 1
    pr_v = 4'b0100;
    pr_or = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) pr_v = 4'b0101;
      #1;
      chk("pr_hold_idx", pr_oi, 2);
      chk("pr_hold_data", pr_od, 8'h22);
      chk("pr_hold_vld", pr_ov, 1);
      chk("pr_hold_rdy", pr_r, 0);
      tick();
    end
    pr_or = 1'b1;
    #1;
    chk("pr_acc_idx", pr_oi, 2);
    chk("pr_acc_rdy", pr_r, 4'b0100);
    tick();
    pr_v = 4'b0001;
    #1;
    chk("pr_next_idx", pr_oi, 0);
    chk("pr_next_data", pr_od, 8'h20);
    chk("pr_next_rdy", pr_r, 4'b0001);
    tick();
    pr_v = '0;
    do_reset();

    // SEL, registered, ready toggling: A0..A7 in order
    s = 0;
    rcv = 0;
    sl_v = 2'b10;
    sl_d[1] = 8'hA0;
    for (int c = 0; c < 40 && rcv < 8; c++) begin
      sl_or = (c % 2 == 0);
      #1;
      if (sl_ov && sl_or) begin
        chk("sel_data", sl_od, 8'hA0 + rcv);
        chk("sel_idx", sl_oi, 1);
        rcv++;
      end
      inf = sl_v[1] && sl_r[1];
      tick();
      if (inf) begin
        s++;
        sl_d[1] = 8'(8'hA0 + s);
        sl_v[1] = (s < 8);
      end
    end
    chk("sel_count", rcv, 8);
    sl_or = 1'b1;
    #1;
    chk("sel_nodup", sl_ov, 0);
    do_reset();

    // SEL, registered, steady ready: one-cycle latency
    sl_or = 1'b1;
    sl_v[1] = 1'b1;
    sl_d[1] = 8'hB0;
    #1;
    chk("lat_empty", sl_ov, 0);
    tick();
    chk("lat_vld0", sl_ov, 1);
    chk("lat_data0", sl_od, 8'hB0);
    sl_d[1] = 8'hB1;
    tick();
    chk("lat_data1", sl_od, 8'hB1);
    sl_v = '0;
    tick();
    chk("lat_drain", sl_ov, 0);
    do_reset();

    // RR registered: stalled 0x55 dropped by reset, pointer back to 0
    rq_d[2] = 8'h55;
    rq_v = 4'b0100;
    rq_or = 1'b0;
    tick();
    rq_v = '0;
    #1;
    chk("rq_full_vld", rq_ov, 1);
    chk("rq_full_data", rq_od, 8'h55);
    chk("rq_full_idx", rq_oi, 2);
    do_reset();
    chk("rq_rst_vld", rq_ov, 0);
    chk("rq_rst_data", rq_od, 0);
    chk("rq_rst_idx", rq_oi, 0);
    rq_or = 1'b1;
    tick();
    chk("rq_no_replay", rq_ov, 0);
    rq_d[2] = 8'h32;
    rq_v = 4'hF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rq_ptr_idx", rq_oi, k);
      chk("rq_ptr_data", rq_od, 8'h30 + k);
    end
    do_reset();

    // N=1 comb pass-through
    o0_v = 1'b1;
    o0_d[0] = 8'h77;
    o0_or = 1'b1;
    #1;
    chk("o0_vld", o0_ov, 1);
    chk("o0_data", o0_od, 8'h77);
    chk("o0_idx", o0_oi, 0);
    chk("o0_rdy", o0_r, 1);
    tick();
    o0_or = 1'b0;
    #1;
    chk("o0_stall_rdy", o0_r, 0);
    chk("o0_stall_vld", o0_ov, 1);
    tick();
    o0_or = 1'b1;
    tick();
    o0_v = '0;
    #1;
    chk("o0_idle", o0_ov, 0);

    // N=1 registered pipeline
    o1_or = 1'b1;
    o1_v = 1'b1;
    o1_d[0] = 8'h88;
    #1;
    chk("o1_empty", o1_ov, 0);
    chk("o1_rdy", o1_r, 1);
    tick();
    chk("o1_vld", o1_ov, 1);
    chk("o1_data", o1_od, 8'h88);
    chk("o1_idx", o1_oi, 0);
    o1_v = '0;
    tick();
    chk("o1_drain", o1_ov, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
